// File: rtl/prog_loader_pkg.sv
// ============================================================================
//  Module   : prog_loader_pkg
//  Purpose  : Shared state encoding and framing constants for the
//             instruction-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  // Loader FSM states (S_CHK is only entered when the checksum build is on)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_WORD   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_CHK    = 3'd6
  } state_e;

  // Header carries a 16-bit big-endian word count
  localparam int HDR_BYTES  = 2;
  // Bytes per instruction word
  localparam int WORD_BYTES = 4;

endpackage : prog_loader_pkg

`default_nettype wire

// File: rtl/prog_loader_byte_word_packer.sv
// ============================================================================
//  Module   : byte_word_packer
//  Purpose  : Packs a stream of bytes MSB-first into 32-bit words. word_valid
//             fires combinationally with the byte that completes a word, and
//             word presents the completed word in that same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  // Only the three earlier bytes need storage; the fourth arrives live
  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  // Shift accepted bytes in and track position within the current word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      idx_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_in};
      idx_q   <= (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_valid && (idx_q == LAST_IDX);

endmodule : byte_word_packer

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Receives a framed byte stream (16-bit count + 4*N payload
//             bytes) and writes big-endian words into instruction memory at
//             consecutive addresses, holding the CPU until a clean load.
//  Options  : define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
//             checksum byte after the payload.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'd0
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prog_en,
  output logic [31:0] inst_addr,
  output logic [31:0] prog_instruction,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  state_e      state_q;
  logic        in_ready_q;
  logic        prog_en_q;
  logic [31:0] inst_addr_q;
  logic [31:0] prog_instr_q;
  logic        cpu_hold_q;
  logic        load_done_q;
  logic        load_err_q;
  logic [15:0] words_q;
  logic [7:0]  count_hi_q;
  logic [15:0] count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q;
`endif

  logic [15:0] count_d;
  logic [15:0] words_d;
  logic        w_hs;
  logic        w_start_ok;
  logic        w_word_hs;
  logic [31:0] w_word;
  logic        w_word_valid;

  assign w_hs       = in_valid && in_ready_q;
  assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_word_hs  = w_hs && (state_q == S_WORD);
  assign count_d    = {count_hi_q, in_data};
  assign words_d    = words_q + 16'd1;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start_ok),
    .byte_valid (w_word_hs),
    .byte_in    (in_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  // Loader FSM: sequences header, payload, writes and completion with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      prog_en_q    <= 1'b0;
      inst_addr_q  <= BASE_ADDR;
      prog_instr_q <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      words_q      <= '0;
      count_hi_q   <= '0;
      count_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      prog_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_HDR_HI;
            in_ready_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            words_q     <= '0;
            inst_addr_q <= BASE_ADDR;
            cpu_hold_q  <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
          end
        end

        S_HDR_HI: begin
          if (w_hs) begin
            count_hi_q <= in_data;
            state_q    <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (w_hs) begin
            count_q <= count_d;
            if (32'(count_d) > MAX_WORDS_U) begin
              // Oversized image: reject without consuming payload
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
              load_err_q  <= 1'b1;
              cpu_hold_q  <= 1'b1;
            end else if (count_d == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q     <= S_CHK;
`else
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
`endif
            end else begin
              state_q <= S_WORD;
            end
          end
        end

        S_WORD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (w_hs) begin
            chk_q <= chk_q ^ in_data;
          end
`endif
          if (w_word_valid) begin
            state_q      <= S_WRITE;
            in_ready_q   <= 1'b0;
            prog_en_q    <= 1'b1;
            prog_instr_q <= w_word;
          end
        end

        S_WRITE: begin
          // Address and count advance once the strobe has been presented
          inst_addr_q <= inst_addr_q + 32'd4;
          words_q     <= words_d;
          if (words_d == count_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q     <= S_CHK;
            in_ready_q  <= 1'b1;
`else
            state_q     <= S_DONE;
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
`endif
          end else begin
            state_q    <= S_WORD;
            in_ready_q <= 1'b1;
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_hs) begin
            state_q     <= S_DONE;
            in_ready_q  <= 1'b0;
            load_done_q <= 1'b1;
            load_err_q  <= (in_data != chk_q);
            cpu_hold_q  <= (in_data != chk_q);
          end
        end
`endif

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign prog_en          = prog_en_q;
  assign inst_addr        = inst_addr_q;
  assign prog_instruction = prog_instr_q;
  assign cpu_hold         = cpu_hold_q;
  assign load_done        = load_done_q;
  assign load_err         = load_err_q;
  assign words_loaded     = words_q;

endmodule : prog_loader

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Scoreboarded bench for prog_loader. Expected memory writes are
//             queued when a load is issued; a monitor pops them on prog_en.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int          MAXW = 1024;
  localparam logic [31:0] BASE = 32'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        prog_en;
  logic [31:0] inst_addr;
  logic [31:0] prog_instruction;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int errors   = 0;
  int checks   = 0;
  int pe_count = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  prog_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .prog_en          (prog_en),
    .inst_addr        (inst_addr),
    .prog_instruction (prog_instruction),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .load_err         (load_err),
    .words_loaded     (words_loaded)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (prog_en === 1'b1) begin
      logic [63:0] e;
      pe_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_prog_en: got write addr=%h data=%h expected no write",
                 inst_addr, prog_instruction);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", inst_addr, e[63:32]);
        check("write_data", prog_instruction, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte after an idle gap; optionally check the write latency and
  // that the loader is still accepting afterwards
  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit expect_write, input bit expect_ready);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (expect_write) check("write_latency", {31'd0, prog_en}, 32'd1);
    if (expect_ready) check("in_ready_held", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue a complete load and check the final status against the stream rules
  task automatic do_load(input int n, input logic [31:0] words[$], input int maxgap, input bit bad_chk);
    logic [7:0]  x;
    logic [7:0]  by;
    logic [31:0] w;
    logic [15:0] nn;
    bit          rej;
    bit          exp_err;
    bit          ready_after_hdr;
    int          t;
    x   = 8'h00;
    nn  = 16'(n);
    rej = (n > MAXW);
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_err         = rej || bad_chk;
    ready_after_hdr = !rej;
`else
    exp_err         = rej;
    ready_after_hdr = !rej && (n != 0);
`endif
    if (!rej) begin
      for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(4 * i), words[i]});
    end
    pulse_start();
    send_byte(nn[15:8], $urandom_range(0, maxgap), 1'b0, 1'b1);
    send_byte(nn[7:0],  $urandom_range(0, maxgap), 1'b0, ready_after_hdr);
`ifndef PROG_LOADER_CHECKSUM_EN
    if (n == 0) check("n0_done_latency", {31'd0, load_done}, 32'd1);
`endif
    if (!rej) begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int b = 0; b < 4; b++) begin
          by = w[31 - 8 * b -: 8];
          x  = x ^ by;
          send_byte(by, $urandom_range(0, maxgap), b == 3, b != 3);
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (x ^ 8'h01) : x, $urandom_range(0, maxgap), 1'b0, 1'b0);
`endif
    end
    t = 0;
    while (load_done !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got load_done=%b expected 1", load_done);
    end
    repeat (2) begin @(posedge clk); #1; end
    check("load_done", {31'd0, load_done}, 32'd1);
    check("load_err",  {31'd0, load_err},  {31'd0, exp_err});
    check("cpu_hold",  {31'd0, cpu_hold},  {31'd0, exp_err});
    check("words_loaded", {16'd0, words_loaded}, rej ? 32'd0 : 32'(n));
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_prog_en"},   {31'd0, prog_en},   32'd0);
    check({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd1);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_load_err"},  {31'd0, load_err},  32'd0);
    check({tag, "_inst_addr"}, inst_addr, BASE);
    check({tag, "_prog_instr"}, prog_instruction, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    logic [31:0] plan[$];
    logic [31:0] rnd[$];
    logic [31:0] one[$];
    logic [31:0] none[$];
    int          pe0;
    int          n;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    plan = '{32'h2008000A, 32'h20090014, 32'h200A001E, 32'h200B0028};

    repeat (3) begin @(posedge clk); #1; end
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // Plan stream back-to-back, then with random idle gaps
    do_load(4, plan, 0, 1'b0);
    do_load(4, plan, 3, 1'b0);

    // Empty image and oversized image
    do_load(0, none, 1, 1'b0);
    do_load(MAXW + 1, none, 0, 1'b0);

    // Reset after 6 payload bytes of a 2-word load: only the first word lands
    pe0 = pe_count;
    exp_q.push_back({BASE, plan[0]});
    pulse_start();
    send_byte(8'h00, 0, 1'b0, 1'b1);
    send_byte(8'h02, 0, 1'b0, 1'b1);
    for (int b = 0; b < 6; b++) begin
      logic [63:0] two;
      two = {plan[0], plan[1]};
      send_byte(two[63 - 8 * b -: 8], 0, b == 3, b != 3);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    check("writes_before_reset", 32'(pe_count - pe0), 32'd1);
    check("rst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    one = '{plan[0], plan[1]};
    do_load(2, one, 0, 1'b0);

    // Randomized images
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 6);
      rnd.delete();
      for (int i = 0; i < n; i++) rnd.push_back($urandom);
      do_load(n, rnd, 2, 1'b0);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    one = '{32'h11223344};
    do_load(1, one, 0, 1'b0);
    do_load(1, one, 0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prog_loader

`default_nettype wire
